vend_ctrl_multi: RTL and testbench

//  Parametrised multi-product vending controller: N products with per-product price and

---
 rtl/vend_ctrl_multi.sv | 241 ++++++++++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_multi.sv
// rtl/vend_ctrl_multi.sv - multi-product vending controller with credit, refund and greedy change payout
module vend_ctrl_multi #(
    parameter int                        NUM_PROD    = 4,
    parameter int                        AMT_W       = 8,
    parameter logic [NUM_PROD*AMT_W-1:0] PRICE_LIST  = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int                        STOCK_W     = 4,
    parameter int                        INIT_STOCK  = 4,
    parameter int                        TIMEOUT_CYC = 1000,
    localparam int                       ID_W        = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin1_i,
    input  logic                coin5_i,
    input  logic                coin10_i,
    input  logic                sel_valid_i,
    input  logic [ID_W-1:0]     sel_id_i,
    input  logic                cancel_i,
    input  logic                restock_vld_i,
    input  logic [ID_W-1:0]     restock_id_i,
    input  logic [STOCK_W-1:0]  restock_qty_i,
    output logic                dispense_o,
    output logic [ID_W-1:0]     dispense_id_o,
    output logic                chg1_o,
    output logic                chg5_o,
    output logic                chg10_o,
    output logic                coin_reject_o,
    output logic                sel_err_o,
    output logic [AMT_W-1:0]    credit_o,
    output logic [NUM_PROD-1:0] sold_out_o,
    output logic                busy_o
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AMT_W-1:0]   AMT_MAX   = {AMT_W{1'b1}};
    localparam logic [STOCK_W-1:0] STOCK_MAX = {STOCK_W{1'b1}};
    localparam logic [STOCK_W-1:0] STOCK_INI = STOCK_W'(INIT_STOCK);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [AMT_W-1:0]     credit_q, credit_d;
    logic [AMT_W-1:0]     price_q, price_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [AMT_W-1:0]     change_q, change_d;
    logic [STOCK_W-1:0]   stock_q [NUM_PROD];
    logic [STOCK_W-1:0]   stock_d [NUM_PROD];
    logic [NUM_PROD-1:0]  sold_out_q, sold_out_d;
    logic                 dispense_q, dispense_d;
    logic [ID_W-1:0]      dispense_id_q, dispense_id_d;
    logic                 chg1_q, chg1_d;
    logic                 chg5_q, chg5_d;
    logic                 chg10_q, chg10_d;
    logic                 reject_q, reject_d;
    logic                 sel_err_q, sel_err_d;
    logic                 busy_q, busy_d;

    // Largest coin not exceeding the amount still owed
    function automatic logic [AMT_W-1:0] coin_of(input logic [AMT_W-1:0] amt);
        if (amt >= AMT_W'(10))     return AMT_W'(10);
        else if (amt >= AMT_W'(5)) return AMT_W'(5);
        else if (amt != '0)        return AMT_W'(1);
        else                       return '0;
    endfunction

    logic                 coin_any;
    logic [AMT_W:0]       coin_sum;
    logic [AMT_W:0]       credit_sum;
    logic [AMT_W-1:0]     nc;
    logic                 sel_ok_id;
    logic [AMT_W-1:0]     payout;
    logic [AMT_W-1:0]     pay_coin;
    logic                 pay_load;

    // Coin value this cycle and saturated credit candidate
    always_comb begin
        coin_any   = coin1_i | coin5_i | coin10_i;
        coin_sum   = (AMT_W+1)'(coin1_i) + (AMT_W+1)'(coin5_i) * (AMT_W+1)'(5)
                   + (AMT_W+1)'(coin10_i) * (AMT_W+1)'(10);
        credit_sum = {1'b0, credit_q} + coin_sum;
        nc         = (credit_sum > {1'b0, AMT_MAX}) ? AMT_MAX : credit_sum[AMT_W-1:0];
        sel_ok_id  = ({1'b0, sel_id_i} < (ID_W+1)'(NUM_PROD));
    end

    // Next-state and registered-output decode for the transaction FSM
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        price_d       = price_q;
        id_d          = id_q;
        timer_d       = timer_q;
        change_d      = change_q;
        dispense_d    = 1'b0;
        dispense_id_d = dispense_id_q;
        sel_err_d     = 1'b0;
        reject_d      = (state_q != S_COLLECT) && coin_any;
        payout        = '0;
        pay_load      = 1'b0;

        case (state_q)
            S_IDLE: begin
                credit_d = '0;
                if (sel_valid_i) begin
                    if (sel_ok_id && (stock_q[sel_id_i] != '0)) begin
                        price_d = PRICE_LIST[sel_id_i*AMT_W +: AMT_W];
                        id_d    = sel_id_i;
                        timer_d = '0;
                        state_d = S_COLLECT;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                credit_d = nc;
                timer_d  = coin_any ? '0 : timer_q + TMR_W'(1);
                if (cancel_i || (timer_q == TMR_W'(TIMEOUT_CYC - 1))) begin
                    // Coins arriving with the cancel are credited, then refunded
                    credit_d = '0;
                    if (nc == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        payout   = nc;
                        pay_load = 1'b1;
                        state_d  = S_CHANGE;
                    end
                end else if (nc >= price_q) begin
                    dispense_d    = 1'b1;
                    dispense_id_d = id_q;
                    state_d       = S_VEND;
                end
            end
            S_VEND: begin
                credit_d = '0;
                if (credit_q != price_q) begin
                    payout   = credit_q - price_q;
                    pay_load = 1'b1;
                    state_d  = S_CHANGE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHANGE: begin
                // change_q is what remains after the coin currently on the outputs
                if (change_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    payout   = change_q;
                    pay_load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pay_coin = coin_of(payout);
        if (pay_load) begin
            change_d = payout - pay_coin;
        end
        chg10_d = pay_load && (pay_coin == AMT_W'(10));
        chg5_d  = pay_load && (pay_coin == AMT_W'(5));
        chg1_d  = pay_load && (pay_coin == AMT_W'(1));
        busy_d  = (state_d != S_IDLE);
    end

    // Stock bookkeeping: vend decrement and saturating restock may hit the same slot
    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) begin
            logic [STOCK_W:0] tmp;
            tmp = {1'b0, stock_q[i]};
            if ((state_q == S_VEND) && (id_q == ID_W'(i))) begin
                tmp = tmp - (STOCK_W+1)'(1);
            end
            if (restock_vld_i && (restock_id_i == ID_W'(i))) begin
                tmp = tmp + {1'b0, restock_qty_i};
            end
            stock_d[i]    = (tmp > {1'b0, STOCK_MAX}) ? STOCK_MAX : tmp[STOCK_W-1:0];
            sold_out_d[i] = (stock_d[i] == '0);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            price_q       <= '0;
            id_q          <= '0;
            timer_q       <= '0;
            change_q      <= '0;
            sold_out_q    <= {NUM_PROD{(STOCK_INI == '0)}};
            dispense_q    <= 1'b0;
            dispense_id_q <= '0;
            chg1_q        <= 1'b0;
            chg5_q        <= 1'b0;
            chg10_q       <= 1'b0;
            reject_q      <= 1'b0;
            sel_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= STOCK_INI;
            end
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            price_q       <= price_d;
            id_q          <= id_d;
            timer_q       <= timer_d;
            change_q      <= change_d;
            sold_out_q    <= sold_out_d;
            dispense_q    <= dispense_d;
            dispense_id_q <= dispense_id_d;
            chg1_q        <= chg1_d;
            chg5_q        <= chg5_d;
            chg10_q       <= chg10_d;
            reject_q      <= reject_d;
            sel_err_q     <= sel_err_d;
            busy_q        <= busy_d;
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign dispense_o    = dispense_q;
    assign dispense_id_o = dispense_id_q;
    assign chg1_o        = chg1_q;
    assign chg5_o        = chg5_q;
    assign chg10_o       = chg10_q;
    assign coin_reject_o = reject_q;
    assign sel_err_o     = sel_err_q;
    assign credit_o      = credit_q;
    assign sold_out_o    = sold_out_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb/tb_vend_ctrl_multi.sv - randomized self-checking bench for vend_ctrl_multi against a transaction model
module tb_vend_ctrl_multi;

    localparam int NP = 4;
    localparam int TO = 40;
    localparam int PRICE [NP] = '{10, 15, 20, 25};

    logic       clk = 1'b0;
    logic       rst;
    logic       coin1, coin5, coin10, sel_valid, cancel, restock_vld;
    logic [1:0] sel_id, restock_id;
    logic [3:0] restock_qty;
    logic       dispense, chg1, chg5, chg10, coin_reject, sel_err, busy;
    logic [1:0] dispense_id;
    logic [7:0] credit;
    logic [3:0] sold_out;

    vend_ctrl_multi #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .coin1_i(coin1), .coin5_i(coin5), .coin10_i(coin10),
        .sel_valid_i(sel_valid), .sel_id_i(sel_id), .cancel_i(cancel),
        .restock_vld_i(restock_vld), .restock_id_i(restock_id), .restock_qty_i(restock_qty),
        .dispense_o(dispense), .dispense_id_o(dispense_id),
        .chg1_o(chg1), .chg5_o(chg5), .chg10_o(chg10),
        .coin_reject_o(coin_reject), .sel_err_o(sel_err),
        .credit_o(credit), .sold_out_o(sold_out), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Transaction-level reference: a collecting flag, a pending vend, and a queue of change coins
    bit m_col, m_vend, m_pay;
    int m_credit, m_price, m_id, m_idle;
    int m_stock [NP];
    int pay_q [$];
    int e_disp, e_id, e_chg, e_rej, e_err, e_busy;
    int n_disp, n_chg_units;

    task automatic push_change(input int amt);
        int a;
        a = amt;
        while (a >= 10) begin pay_q.push_back(10); a -= 10; end
        while (a >= 5)  begin pay_q.push_back(5);  a -= 5;  end
        while (a >= 1)  begin pay_q.push_back(1);  a -= 1;  end
    endtask

    task automatic model_reset();
        m_col = 0; m_vend = 0; m_pay = 0;
        m_credit = 0; m_price = 0; m_id = 0; m_idle = 0;
        for (int i = 0; i < NP; i++) m_stock[i] = 4;
        pay_q.delete();
        e_disp = 0; e_id = 0; e_chg = 0; e_rej = 0; e_err = 0; e_busy = 0;
    endtask

    task automatic model_step();
        int coins, nc;
        bit was_col, was_vend, was_pay;
        if (rst) begin
            model_reset();
            return;
        end
        coins = int'(coin1) + 5 * int'(coin5) + 10 * int'(coin10);
        was_col = m_col; was_vend = m_vend; was_pay = m_pay;
        e_disp = 0; e_chg = 0; e_rej = 0; e_err = 0;
        if (was_col) begin
            nc = m_credit + coins;
            if (nc > 255) nc = 255;
            if (cancel || m_idle == TO - 1) begin
                m_col = 0; m_credit = 0;
                push_change(nc);
            end else if (nc >= m_price) begin
                m_col = 0; m_vend = 1; m_credit = nc;
                e_disp = 1; e_id = m_id;
            end else begin
                m_credit = nc;
                m_idle = (coins > 0) ? 0 : m_idle + 1;
            end
        end else begin
            e_rej = (coins > 0);
            if (was_vend) begin
                m_vend = 0;
                m_stock[m_id]--;
                push_change(m_credit - m_price);
                m_credit = 0;
            end else if (!was_pay && sel_valid) begin
                if (int'(sel_id) < NP && m_stock[sel_id] > 0) begin
                    m_col = 1; m_credit = 0; m_idle = 0;
                    m_price = PRICE[sel_id]; m_id = int'(sel_id);
                end else begin
                    e_err = 1;
                end
            end
        end
        if (restock_vld && int'(restock_id) < NP) begin
            m_stock[restock_id] += int'(restock_qty);
            if (m_stock[restock_id] > 15) m_stock[restock_id] = 15;
        end
        if (pay_q.size() > 0) e_chg = pay_q.pop_front();
        m_pay = (e_chg != 0);
        e_busy = m_col || m_vend || m_pay;
    endtask

    task automatic clear_inputs();
        coin1 = 0; coin5 = 0; coin10 = 0; sel_valid = 0; sel_id = 0;
        cancel = 0; restock_vld = 0; restock_id = 0; restock_qty = 0;
    endtask

    // One clock: inputs already set by the caller, model follows the edge, outputs compared after it
    task automatic tick();
        int so;
        @(posedge clk);
        model_step();
        #1;
        so = 0;
        for (int i = 0; i < NP; i++) if (m_stock[i] == 0) so |= (1 << i);
        check("dispense", int'(dispense), e_disp);
        check("dispense_id", int'(dispense_id), e_id);
        check("chg10", int'(chg10), int'(e_chg == 10));
        check("chg5", int'(chg5), int'(e_chg == 5));
        check("chg1", int'(chg1), int'(e_chg == 1));
        check("coin_reject", int'(coin_reject), e_rej);
        check("sel_err", int'(sel_err), e_err);
        check("busy", int'(busy), e_busy);
        check("credit", int'(credit), m_credit);
        check("sold_out", int'(sold_out), so);
        if (dispense) n_disp++;
        n_chg_units += int'(chg1) + 5 * int'(chg5) + 10 * int'(chg10);
        clear_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic sel(input int id);
        sel_valid = 1; sel_id = 2'(id); tick();
    endtask

    initial begin
        clear_inputs();
        n_disp = 0; n_chg_units = 0;
        model_reset();
        do_reset();
        check("reset_busy", int'(busy), 0);
        check("reset_credit", int'(credit), 0);
        check("reset_sold_out", int'(sold_out), 0);

        // Exact price: product 1 (15) with 10 then 5
        sel(1); coin10 = 1; tick(); coin5 = 1; tick();
        check("exact_dispense", int'(dispense), 1);
        check("exact_id", int'(dispense_id), 1);
        idle(4);
        check("exact_stock1", m_stock[1], 3);

        // Product 0 (10) with 16 in one cycle -> change 5 then 1
        sel(0); coin10 = 1; coin5 = 1; coin1 = 1; tick();
        tick();
        check("chg_first5", int'(chg5), 1);
        tick();
        check("chg_then1", int'(chg1), 1);
        idle(3);

        // Cancel with a coin in the same cycle: 15 refunded as 10, 5
        sel(3); coin10 = 1; tick(); cancel = 1; coin5 = 1; tick();
        check("cancel_chg10", int'(chg10), 1);
        idle(4);
        check("cancel_idle", int'(busy), 0);

        // Timeout with no credit, then with credit 6
        sel(2); idle(TO + 3);
        check("timeout_empty", int'(busy), 0);
        sel(2); coin5 = 1; tick(); coin1 = 1; tick(); idle(TO + 4);

        // Sell out product 0, reject selection, then restock
        do_reset();
        for (int k = 0; k < 4; k++) begin
            sel(0); coin10 = 1; tick(); idle(3);
        end
        check("sold_out0", int'(sold_out[0]), 1);
        sel(0);
        check("sel_err_sold", int'(sel_err), 1);
        idle(2);
        restock_vld = 1; restock_id = 0; restock_qty = 2; tick(); tick();
        check("restocked0", int'(sold_out[0]), 0);
        check("restock_qty", m_stock[0], 2);

        // Coin during change is rejected; reset mid-collect
        sel(3); coin10 = 1; coin5 = 1; coin1 = 1; tick(); coin10 = 1; tick();
        tick(); coin10 = 1; tick(); idle(4);
        sel(1); coin5 = 1; tick(); rst = 1; tick(); rst = 0; tick();
        check("rst_credit", int'(credit), 0);
        idle(2);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            coin1  = ($urandom_range(0, 99) < 6);
            coin5  = ($urandom_range(0, 99) < 5);
            coin10 = ($urandom_range(0, 99) < 5);
            sel_valid = (r < 12);
            sel_id = 2'($urandom_range(0, 3));
            cancel = ($urandom_range(0, 99) < 2);
            restock_vld = ($urandom_range(0, 99) < 3);
            restock_id = 2'($urandom_range(0, 3));
            restock_qty = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 999) < 2);
            tick();
            rst = 0;
        end
        check("some_vends", int'(n_disp > 10), 1);
        check("some_change", int'(n_chg_units > 10), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
